sign_to_image: RTL and testbench
================================

Name: sign_to_image

Overview:
- Synthetic gesture renderer: inverse of the sign recognizer.
- Accepts a sign code (finger count) and a palm height, then emits a binary hand image as a serial raster bitstream `object_image`, one pixel per clock.
- Feeds the recognizer's `object_image` input for closed-loop self-test and regression without file-based stimulus.

Parameters:
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in rows
- PALM_X0, 8, leftmost palm column
- PALM_W, 16, palm width in columns
- FINGER_W, 2, finger width in columns
- FINGER_GAP, 1, columns between adjacent fingers
- FINGER_H, 8, finger height in rows
- MAX_FINGERS, 5, largest legal sign_value
- BLANK_CYCLES, 4, idle cycles after each frame before next accept

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sign_value  in  4  requested finger count
- palm_height  in  8  palm height in rows
- sign_valid  in  1  request valid
- sign_ready  out  1  block can accept request
- object_image  out  1  serial pixel, 1 = hand
- pixel_valid  out  1  object_image valid this cycle
- frame_start  out  1  pulse with pixel (row 0, col 0)
- frame_end  out  1  pulse with pixel (IMG_H-1, IMG_W-1)
- sign_error  out  1  one-cycle pulse on rejected request
- busy  out  1  high in RENDER or BLANK

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0 except sign_ready = 1.
  - State IDLE; row/col counters 0; latched request cleared.
- States:
  - IDLE: sign_ready = 1. Handshake when sign_valid & sign_ready.
    - Legal request (sign_value <= MAX_FINGERS): latch inputs, go to RENDER.
    - Illegal request: sign_error = 1 on the next cycle, stay IDLE, emit no pixels.
  - RENDER: pixel_valid = 1 for exactly IMG_W*IMG_H consecutive cycles, row-major.
    - Col increments every cycle. Wrap col IMG_W-1 -> 0 increments row.
    - After the last pixel, go to BLANK.
  - BLANK: pixel_valid = 0 for BLANK_CYCLES cycles, then IDLE.
  - sign_ready = 0 in RENDER and BLANK.
- Latency: handshake at cycle T puts pixel (0,0) at T+1.
  - Frame period is IMG_W*IMG_H + BLANK_CYCLES + 1 cycles, including the IDLE accept cycle.
- Output timing: all outputs are registered. frame_start and frame_end are single-cycle and coincident with pixel_valid.
- Geometry, computed on latched values:
  - ph = min(palm_height, IMG_H - FINGER_H).
  - Palm is 1 for rows [IMG_H-ph, IMG_H-1] and cols [PALM_X0, PALM_X0+PALM_W-1]. ph = 0 means no palm rows.
  - Finger k, for k = 0..n-1 with n = latched sign_value: 1 for rows [IMG_H-ph-FINGER_H, IMG_H-ph-1] and cols starting at PALM_X0 + k*(FINGER_W+FINGER_GAP), width FINGER_W.
  - All other pixels are 0.
- Input stability: inputs that change during RENDER or BLANK are ignored. sign_valid held high through a frame is accepted again on the first IDLE cycle.
- Reset mid-frame: the next cycle is IDLE with outputs at reset values. No frame_end is emitted for the aborted frame.
- Parameter constraint: MAX_FINGERS*FINGER_W + (MAX_FINGERS-1)*FINGER_GAP <= PALM_W. Enforce with an elaboration-time check.

Optional Feature:
- Macro: SIGN_TO_IMAGE_LFSR_NOISE_EN
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset.
  - Advances once per RENDER cycle.
  - Output pixel is inverted when lfsr[7:0] == 8'h00.
  - Noise is deterministic and reproducible from reset.
- Undefined: no LFSR logic is instantiated; the image is exact.

Test Plan:
- sign 3, palm 10, defaults -> palm rows 22..31, cols 8..23; fingers rows 14..21, cols 8-9, 11-12, 14-15; 208 ones total; frame_start at T+1, frame_end at T+1024.
- sign 0, palm 4 -> only palm rows 28..31, cols 8..23; 64 ones; no pixels in rows 20..27.
- sign 5, palm 40 -> ph clamped to 24; palm rows 8..31 (384 ones) plus fingers rows 0..7 (80 ones); 464 ones total.
- sign 9 with sign_valid -> sign_error pulses 1 cycle; pixel_valid stays 0; sign_ready stays 1.
- sign_valid held high, sign 2, palm 6 -> back-to-back frames; the second frame_start comes exactly 1029 cycles after the first; inputs changed mid-frame do not affect the current frame.
- rst asserted at pixel 500 -> next cycle pixel_valid = 0, sign_ready = 1, busy = 0; no frame_end; a new request renders from (0,0).

Source files
------------

// File: rtl/sign_to_image.sv
// sign_to_image: synthetic hand-gesture renderer.
//   Accepts a finger count (sign_value) and a palm height. It then emits a binary
//   IMG_W x IMG_H hand image as a serial row-major raster, one pixel per clock.
//   Its output feeds the recognizer's object_image input for closed-loop self-test.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sign_value    : requested finger count (legal 0..MAX_FINGERS)
//   palm_height   : palm height in rows (clamped to IMG_H-FINGER_H)
//   sign_valid    : request valid; sign_ready high when a request can be taken
//   object_image  : serial pixel, 1 = hand; qualified by pixel_valid
//   frame_start   : pulse with pixel (0,0); frame_end pulse with the last pixel
//   sign_error    : one-cycle pulse after a rejected (out-of-range) request
//   busy          : high while rendering or blanking
//
// Optional feature: define SIGN_TO_IMAGE_LFSR_NOISE_EN to add a 16-bit LFSR
// that inverts a pseudo-random subset of pixels (reproducible from reset).
module sign_to_image #(
  parameter int unsigned IMG_W        = 32,
  parameter int unsigned IMG_H        = 32,
  parameter int unsigned PALM_X0      = 8,
  parameter int unsigned PALM_W       = 16,
  parameter int unsigned FINGER_W     = 2,
  parameter int unsigned FINGER_GAP   = 1,
  parameter int unsigned FINGER_H     = 8,
  parameter int unsigned MAX_FINGERS  = 5,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sign_value,
  input  logic [7:0] palm_height,
  input  logic       sign_valid,
  output logic       sign_ready,
  output logic       object_image,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       sign_error,
  output logic       busy
);

  localparam int unsigned RowW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned ColW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned PhMax  = IMG_H - FINGER_H;
  localparam int unsigned Pitch  = FINGER_W + FINGER_GAP;

  // All fingers must fit across the palm.
  if (MAX_FINGERS * FINGER_W + (MAX_FINGERS - 1) * FINGER_GAP > PALM_W) begin : g_bad_geometry
    $error("sign_to_image: fingers do not fit within PALM_W");
  end

  typedef enum logic [1:0] {StIdle, StRender, StBlank} state_e;

  state_e              r_state, w_state_d;
  logic [RowW-1:0]     r_row, w_row_d;
  logic [ColW-1:0]     r_col, w_col_d;
  logic [BlankW-1:0]   r_blank, w_blank_d;
  logic [3:0]          r_sign, w_sign_d;
  logic [7:0]          r_ph, w_ph_d;
  logic                w_err_d;

  logic r_sign_ready, r_image, r_pixel_valid, r_frame_start, r_frame_end;
  logic r_sign_error, r_busy;

  logic        w_legal;
  logic [7:0]  w_ph_clamp;
  logic        w_last_pix;
  logic [31:0] w_rr, w_cc, w_pp;
  logic        w_pix;
  logic        w_noise;
  logic        w_render_d;

  assign w_legal    = (32'(sign_value) <= MAX_FINGERS);
  assign w_ph_clamp = (32'(palm_height) > PhMax) ? 8'(PhMax) : palm_height;
  assign w_last_pix = (r_row == RowW'(IMG_H - 1)) && (r_col == ColW'(IMG_W - 1));

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_col_d   = r_col;
    w_blank_d = r_blank;
    w_sign_d  = r_sign;
    w_ph_d    = r_ph;
    w_err_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // sign_ready is high throughout IDLE, so sign_valid alone is the handshake.
        if (sign_valid) begin
          if (w_legal) begin
            w_state_d = StRender;
            w_row_d   = '0;
            w_col_d   = '0;
            w_sign_d  = sign_value;
            w_ph_d    = w_ph_clamp;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StRender: begin
        if (w_last_pix) begin
          w_state_d = StBlank;
          w_row_d   = '0;
          w_col_d   = '0;
          w_blank_d = '0;
        end else if (r_col == ColW'(IMG_W - 1)) begin
          w_col_d = '0;
          w_row_d = r_row + 1'b1;
        end else begin
          w_col_d = r_col + 1'b1;
        end
      end
      StBlank: begin
        if (r_blank == BlankW'(BLANK_CYCLES - 1)) begin
          w_state_d = StIdle;
        end else begin
          w_blank_d = r_blank + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Pixel for the coordinate that becomes current next cycle, so outputs stay registered.
  assign w_rr       = 32'(w_row_d);
  assign w_cc       = 32'(w_col_d);
  assign w_pp       = 32'(w_ph_d);
  assign w_render_d = (w_state_d == StRender);

  always_comb begin
    w_pix = 1'b0;
    if ((w_rr + w_pp >= IMG_H) && (w_cc >= PALM_X0) && (w_cc < PALM_X0 + PALM_W)) begin
      w_pix = 1'b1;
    end
    if ((w_rr + w_pp < IMG_H) && (w_rr + w_pp + FINGER_H >= IMG_H)) begin
      for (int unsigned k = 0; k < MAX_FINGERS; k++) begin
        if ((k < 32'(w_sign_d)) && (w_cc >= PALM_X0 + k * Pitch) &&
            (w_cc < PALM_X0 + k * Pitch + FINGER_W)) begin
          w_pix = 1'b1;
        end
      end
    end
  end

`ifdef SIGN_TO_IMAGE_LFSR_NOISE_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  // Fibonacci taps 16,14,13,11.
  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_noise = (r_lfsr[7:0] == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (w_render_d) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end
`else
  assign w_noise = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_row         <= '0;
      r_col         <= '0;
      r_blank       <= '0;
      r_sign        <= '0;
      r_ph          <= '0;
      r_sign_ready  <= 1'b1;
      r_image       <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_sign_error  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_row         <= w_row_d;
      r_col         <= w_col_d;
      r_blank       <= w_blank_d;
      r_sign        <= w_sign_d;
      r_ph          <= w_ph_d;
      r_sign_ready  <= (w_state_d == StIdle);
      r_busy        <= (w_state_d != StIdle);
      r_pixel_valid <= w_render_d;
      r_image       <= w_render_d & (w_pix ^ w_noise);
      r_frame_start <= w_render_d && (w_row_d == '0) && (w_col_d == '0);
      r_frame_end   <= w_render_d && (w_row_d == RowW'(IMG_H - 1)) &&
                       (w_col_d == ColW'(IMG_W - 1));
      r_sign_error  <= w_err_d;
    end
  end

  assign sign_ready   = r_sign_ready;
  assign object_image = r_image;
  assign pixel_valid  = r_pixel_valid;
  assign frame_start  = r_frame_start;
  assign frame_end    = r_frame_end;
  assign sign_error   = r_sign_error;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sign_to_image.sv
// Testbench for sign_to_image (default build, exact image).
module tb_sign_to_image;

  localparam int W = 32;
  localparam int H = 32;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sign_value = '0;
  logic [7:0] palm_height = '0;
  logic       sign_valid = 1'b0;
  logic       sign_ready, object_image, pixel_valid, frame_start, frame_end;
  logic       sign_error, busy;

  sign_to_image dut (
    .clk         (clk),
    .rst         (rst),
    .sign_value  (sign_value),
    .palm_height (palm_height),
    .sign_valid  (sign_valid),
    .sign_ready  (sign_ready),
    .object_image(object_image),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .sign_error  (sign_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int sign;
    int palm;
    int ones;
    bit err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference image: bit c of each word is column c of that row.
  task automatic push_expected(input int s, input int p);
    int ph;
    ph = (p > H - 8) ? H - 8 : p;
    for (int r = 0; r < H; r++) begin
      logic [31:0] w;
      w = '0;
      for (int c = 0; c < W; c++) begin
        if (r >= H - ph && c >= 8 && c <= 23) w[c] = 1'b1;
        for (int k = 0; k < s; k++)
          if (r >= H - ph - 8 && r <= H - ph - 1 && c >= 8 + 3 * k && c <= 9 + 3 * k)
            w[c] = 1'b1;
      end
      exp_q.push_back(w);
    end
  endtask

  // Called at a negedge; drives the request through one sampling edge.
  // Returns at the next negedge with t_req = cycle in which pixel (0,0) is expected.
  task automatic send_req(input int s, input int p, input bit hold, output int t_req);
    sign_value  = 4'(s);
    palm_height = 8'(p);
    sign_valid  = 1'b1;
    t_req = cyc + 1;
    @(negedge clk);
    if (!hold) sign_valid = 1'b0;
  endtask

  // Starts checking at the current negedge; waits (bounded) for the first pixel.
  task automatic capture_frame(input string tag, input int exp_ones, output int start_cyc);
    int waited = 0;
    int ones = 0;
    int bad = 0;
    logic [31:0] row;
    start_cyc = -1;
    while (!pixel_valid && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!pixel_valid) begin
      check({tag, "_timeout"}, 32'(waited), 32'(0));
      return;
    end
    start_cyc = cyc;
    row = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (i > 0) @(negedge clk);
      if (!pixel_valid || frame_start !== (i == 0) || frame_end !== (i == NPIX - 1)) bad++;
      row[i % W] = object_image;
      if (object_image === 1'b1) ones++;
      if (i % W == W - 1) begin
        if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'(1), 32'(0));
        else check($sformatf("%s_row%0d", tag, i / W), row, exp_q.pop_front());
      end
    end
    check({tag, "_framing"}, 32'(bad), 32'(0));
    check({tag, "_ones"}, 32'(ones), 32'(exp_ones));
  endtask

  // From the last-pixel negedge: counts negedges until sign_ready returns.
  task automatic wait_ready(output int gap, output int bad);
    gap = 0;
    bad = 0;
    while (!sign_ready && gap < 50) begin
      @(negedge clk);
      gap++;
      if (!sign_ready && (!busy || pixel_valid)) bad++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int t_req, st, st1, st2, gap, bad, quiet;
    vecs[0] = '{sign: 3, palm: 10,  ones: 208, err: 1'b0};
    vecs[1] = '{sign: 0, palm: 4,   ones: 64,  err: 1'b0};
    vecs[2] = '{sign: 5, palm: 40,  ones: 464, err: 1'b0};
    vecs[3] = '{sign: 9, palm: 10,  ones: 0,   err: 1'b1};
    vecs[4] = '{sign: 1, palm: 0,   ones: 16,  err: 1'b0};
    vecs[5] = '{sign: 15, palm: 0,  ones: 0,   err: 1'b1};
    vecs[6] = '{sign: 5, palm: 24,  ones: 464, err: 1'b0};
    vecs[7] = '{sign: 4, palm: 255, ones: 448, err: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", sign_ready, 1);
    check("rst_outs", {object_image, pixel_valid, frame_start, frame_end, sign_error, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", {sign_ready, pixel_valid, busy}, 32'b100);

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (!vecs[i].err) push_expected(vecs[i].sign, vecs[i].palm);
      send_req(vecs[i].sign, vecs[i].palm, 1'b0, t_req);
      if (vecs[i].err) begin
        check({tag, "_err_pulse"}, sign_error, 1);
        check({tag, "_err_nopix"}, pixel_valid, 0);
        check({tag, "_err_ready"}, sign_ready, 1);
        @(negedge clk);
        check({tag, "_err_single"}, sign_error, 0);
        quiet = 0;
        repeat (6) begin
          if (pixel_valid || !sign_ready || busy) quiet++;
          @(negedge clk);
        end
        check({tag, "_err_quiet"}, 32'(quiet), 0);
      end else begin
        capture_frame(tag, vecs[i].ones, st);
        check({tag, "_latency"}, 32'(st), 32'(t_req));
        wait_ready(gap, bad);
        check({tag, "_ready_gap"}, 32'(gap), 32'(5));
        check({tag, "_blank_state"}, 32'(bad), 0);
        check({tag, "_idle_busy"}, busy, 0);
      end
    end

    // Back-to-back frames with sign_valid held; inputs change mid-frame.
    push_expected(2, 6);
    send_req(2, 6, 1'b1, t_req);
    fork
      begin
        capture_frame("b2b1", 128, st1);
        @(negedge clk);
        capture_frame("b2b2", 256, st2);
      end
      begin
        repeat (100) @(negedge clk);
        sign_value  = 4'd4;
        palm_height = 8'd12;
        push_expected(4, 12);
        repeat (1100) @(negedge clk);
        sign_valid = 1'b0;
      end
    join
    check("b2b_latency", 32'(st1), 32'(t_req));
    check("b2b_period", 32'(st2 - st1), 32'(1029));
    wait_ready(gap, bad);
    check("b2b_ready_gap", 32'(gap), 32'(5));
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (pixel_valid) quiet++;
    end
    check("b2b_no_third", 32'(quiet), 0);

    // Reset in the middle of a frame
    push_expected(3, 10);
    send_req(3, 10, 1'b0, t_req);
    repeat (500) @(negedge clk);
    check("mid_rendering", pixel_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", sign_ready, 1);
    check("mid_rst_outs", {object_image, pixel_valid, frame_start, frame_end, sign_error, busy}, 0);
    rst = 1'b0;
    exp_q.delete();
    quiet = 0;
    repeat (1100) begin
      @(negedge clk);
      if (frame_end || pixel_valid) quiet++;
    end
    check("mid_no_frame_end", 32'(quiet), 0);
    push_expected(0, 4);
    send_req(0, 4, 1'b0, t_req);
    capture_frame("post_rst", 64, st);
    check("post_rst_latency", 32'(st), 32'(t_req));
    wait_ready(gap, bad);
    check("post_rst_ready_gap", 32'(gap), 32'(5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
